bank_req_ctrl: RTL and testbench

//  Initiator side of the per-bank memory request interface: one instance per bank (`MACH_N total).

---
 rtl/aoc4_pkg.sv | 33 +++
 rtl/req_fifo.sv | 53 +++++
 rtl/bank_req_ctrl.sv | 146 ++++++++++++++
 tb/tb_bank_req_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc4_pkg.sv
// Shared types for the per-bank request initiator: request record and FSM states.
// Bus widths fall back to local defaults when the project-wide defines are absent.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 10
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 4
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 32
`endif

package aoc4_pkg;

  localparam int ROW_W  = `BANK_ADDR_WIDTH;
  localparam int COL_W  = `COL_ADDR_WIDTH;
  localparam int DATA_W = `TX_DATA_WIDTH;

  typedef struct packed {
    logic              write;
    logic              pad;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } bank_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } bank_req_state_t;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous FIFO of bank requests with a combinational head view.
// Simultaneous push and pop are accepted even when full.
module req_fifo import aoc4_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      i_push,
  input  bank_req_t i_data,
  input  logic      i_pop,
  output bank_req_t o_data,
  output logic      o_empty,
  output logic      o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  bank_req_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && ((r_count != FULL_CNT) || w_pop);
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/bank_req_ctrl.sv
// Per-bank request initiator: queues core commands, issues one at a time to the
// bank controller, returns read data, and aborts requests whose ack never arrives.
module bank_req_ctrl import aoc4_pkg::*; #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_pad,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [COL_W-1:0]  cmd_col,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              mem_pad_en,
  output logic [ROW_W-1:0]  mem_row_addr,
  output logic [COL_W-1:0]  mem_col_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout,
  output logic              idle
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  bank_req_state_t   r_state;
  bank_req_state_t   w_state_next;
  bank_req_t         r_req;
  bank_req_t         w_cmd;
  bank_req_t         w_head;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_ack_read;
  logic              w_timeout;
  logic [WD_W-1:0]   r_wdog;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_err_timeout;

  assign w_cmd  = '{write: cmd_write, pad: cmd_pad, row: cmd_row, col: cmd_col, data: cmd_data};
  assign w_push = cmd_valid && cmd_ready;

  req_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_ack_read   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && !r_rsp_valid) begin
          w_pop        = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        // An ack landing on the last watchdog cycle takes priority over the abort.
        if (mem_ack) begin
          w_ack_read   = !r_req.write;
          w_state_next = r_req.write ? IDLE : RESP;
        end else if (r_wdog == WD_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = r_req.write ? IDLE : RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_wdog        <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_req  <= w_head;
        r_wdog <= '0;
      end else if (r_state == ISSUE) begin
        r_wdog <= r_wdog + 1'b1;
      end
      if (w_ack_read) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= mem_rdata;
        r_rsp_err   <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
        if (!r_req.write) begin
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b1;
        end
      end else if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Bank-side outputs are gated by state so they fall to zero the instant reset asserts.
  assign w_issue      = (r_state == ISSUE);
  assign mem_read_en  = w_issue && !r_req.write;
  assign mem_write_en = w_issue && r_req.write;
  assign mem_pad_en   = w_issue && r_req.write && r_req.pad;
  assign mem_row_addr = w_issue ? r_req.row  : '0;
  assign mem_col_addr = w_issue ? r_req.col  : '0;
  assign mem_wdata    = w_issue ? r_req.data : '0;

  assign cmd_ready   = !w_fifo_full;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign err_timeout = r_err_timeout;
  assign idle        = w_fifo_empty && (r_state == IDLE) && !r_rsp_valid;

endmodule

// File: tb/tb_bank_req_ctrl.sv
// Bench for bank_req_ctrl: bank-controller model with programmable ack delay plus a
// transaction-level reference (expected request order, memory image, response list).
module tb_bank_req_ctrl;
  import aoc4_pkg::*;

  localparam int TO = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_write, cmd_pad;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_read_en, mem_write_en, mem_pad_en;
  logic [ROW_W-1:0]  mem_row_addr;
  logic [COL_W-1:0]  mem_col_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_timeout, idle;

  always #5 clock = ~clock;

  bank_req_ctrl #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_pad(cmd_pad),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_pad_en(mem_pad_en),
    .mem_row_addr(mem_row_addr), .mem_col_addr(mem_col_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout), .idle(idle)
  );

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference state and bank-model knobs
  bank_req_t         exp_req[$];
  rsp_t              exp_rsp[$];
  logic [DATA_W-1:0] ref_mem  [int];
  logic [DATA_W-1:0] bank_mem [int];
  int  ack_delay = 0;
  bit  stall = 0, never_ack = 0, no_commit = 0;
  int  rsp_mode = 0;
  bit  lat_armed = 0;
  int  lat_t0 = -1;
  bit  gap_armed = 0;
  int  gap_rises = 0;
  int  cyc = 0;

  function automatic int key(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return int'({r, c});
  endfunction

  always @(posedge clock) cyc = cyc + 1;

  // Monitor first, then drive the bank model and rsp_ready for the next edge.
  bank_req_t m_cur, m_e, p_req;
  rsp_t      m_r, p_rsp, m_obs;
  logic      m_en, p_en;
  bit        p_hold, ack_rd_pend;
  int        hi_run, lo_run, ack_cnt;

  always @(negedge clock) begin
    if (!reset_n) begin
      p_en = 1'b0; p_hold = 0; ack_rd_pend = 0;
      hi_run = 0; lo_run = 0; ack_cnt = 0;
      mem_ack = 1'b0;
    end else begin
      case (rsp_mode)
        1:       rsp_ready = 1'b0;
        2:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b1;
      endcase
      m_en  = mem_read_en | mem_write_en;
      m_cur = '{write: mem_write_en, pad: mem_pad_en, row: mem_row_addr,
                col: mem_col_addr, data: mem_wdata};
      m_obs = {rsp_err, rsp_data};
      if (ack_rd_pend) check("rsp_latency", rsp_valid, 1'b1);
      ack_rd_pend = 0;
      if (m_en) check("one_enable", mem_read_en & mem_write_en, 1'b0);
      if (m_en && !p_en) begin
        if (exp_req.size() == 0) begin
          check("unexpected_req", m_en, 1'b0);
        end else begin
          m_e = exp_req.pop_front();
          check("req_type", m_cur.write, m_e.write);
          check("req_pad_row_col", {m_cur.pad, m_cur.row, m_cur.col}, {m_e.pad, m_e.row, m_e.col});
          if (m_e.write) check("req_wdata", m_cur.data, m_e.data);
          $display("REQ t=%0d %s row=%0d col=%0d", cyc, m_cur.write ? "WR" : "RD", m_cur.row, m_cur.col);
        end
        if (lat_armed) begin
          check("issue_latency", cyc - lat_t0, 2);
          lat_armed = 0;
        end
        if (gap_armed) begin
          if (gap_rises > 0) check("enable_gap", lo_run, 1);
          gap_rises++;
        end
        hi_run = 0;
      end
      if (m_en && p_en) check("req_stable", m_cur, p_req);
      if (!m_en && p_en && never_ack) check("timeout_len", hi_run, TO);
      if (m_en) begin hi_run++; lo_run = 0; end
      else lo_run++;
      if (p_hold) begin
        check("rsp_valid_hold", rsp_valid, 1'b1);
        check("rsp_fields_hold", m_obs, p_rsp);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          m_r = exp_rsp.pop_front();
          check("rsp_err", rsp_err, m_r.err);
          check("rsp_data", rsp_data, m_r.data);
          $display("RSP t=%0d data=%0h err=%0d", cyc, rsp_data, rsp_err);
        end
      end
      p_hold = rsp_valid && !rsp_ready;
      p_rsp  = m_obs;
      p_en   = m_en;
      p_req  = m_cur;
      // Bank controller model
      if (m_en) begin
        if (!stall && !never_ack && ack_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_write_en) begin
            bank_mem[key(mem_row_addr, mem_col_addr)] = mem_wdata;
          end else begin
            mem_rdata = bank_mem.exists(key(mem_row_addr, mem_col_addr)) ?
                        bank_mem[key(mem_row_addr, mem_col_addr)] : '0;
            ack_rd_pend = 1;
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        ack_cnt++;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        ack_cnt   = 0;
      end
    end
  end

  // Offer one command; record what the bank should see and what the core should get back.
  task automatic push(input logic w, input logic pad, input logic [ROW_W-1:0] row,
                      input logic [COL_W-1:0] col, input logic [DATA_W-1:0] data);
    int        tries = 0;
    bank_req_t e;
    rsp_t      r;
    cmd_valid = 1'b1; cmd_write = w; cmd_pad = pad;
    cmd_row = row; cmd_col = col; cmd_data = data;
    while (!cmd_ready && tries < 300) begin
      @(negedge clock);
      tries++;
    end
    if (!cmd_ready) begin
      check("push_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    e = '{write: w, pad: w ? pad : 1'b0, row: row, col: col, data: data};
    exp_req.push_back(e);
    if (w) begin
      if (!never_ack && !no_commit) ref_mem[key(row, col)] = data;
    end else begin
      r.err  = never_ack;
      r.data = never_ack ? '0 : (ref_mem.exists(key(row, col)) ? ref_mem[key(row, col)] : '0);
      exp_rsp.push_back(r);
    end
    if (lat_armed && lat_t0 < 0) lat_t0 = cyc;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(idle && exp_req.size() == 0 && exp_rsp.size() == 0) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check(tag, idle && exp_req.size() == 0 && exp_rsp.size() == 0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    cmd_valid = 0; cmd_write = 0; cmd_pad = 0; cmd_row = '0; cmd_col = '0; cmd_data = '0;
    rsp_ready = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mem_outputs", {mem_read_en, mem_write_en, mem_pad_en, mem_row_addr, mem_col_addr, mem_wdata}, '0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
    check("rst_err_timeout", err_timeout, 1'b0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_idle", idle, 1'b1);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // 1: write then read back the same cell; first issue two cycles after acceptance
    ack_delay = 3; lat_armed = 1; lat_t0 = -1;
    push(1'b1, 1'b1, ROW_W'(3), COL_W'(1), DATA_W'('h5A));
    push(1'b0, 1'b0, ROW_W'(3), COL_W'(1), '0);
    drain("t1_drain");
    check("t1_no_timeout", err_timeout, 1'b0);

    // 2: bank stalls; one request goes in flight, four more fill the queue
    stall = 1; ack_delay = 0;
    for (int i = 0; i < 5; i++)
      push(1'b1, 1'(i), ROW_W'(i + 4), COL_W'(i), $urandom);
    check("t2_queue_full", cmd_ready, 1'b0);
    stall = 0;
    push(1'b1, 1'b0, ROW_W'(20), COL_W'(9), $urandom);
    drain("t2_drain");

    // 3: response back-pressure blocks further issue
    rsp_mode = 1;
    push(1'b0, 1'b0, ROW_W'(3), COL_W'(1), '0);
    push(1'b1, 1'b0, ROW_W'(7), COL_W'(7), $urandom);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clock); n++; end
    check("t3_rsp_arrives", rsp_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("t3_no_issue", mem_read_en | mem_write_en, 1'b0);
      check("t3_not_idle", idle, 1'b0);
    end
    rsp_mode = 0;
    drain("t3_drain");

    // ack on the final watchdog cycle still counts as success
    ack_delay = TO - 1;
    push(1'b0, 1'b0, ROW_W'(4), COL_W'(0), '0);
    drain("ack_wins_drain");
    check("ack_wins_no_err", err_timeout, 1'b0);

    // 4: lost acks abort a read (error response) and a write (no response)
    never_ack = 1;
    push(1'b0, 1'b0, ROW_W'(5), COL_W'(5), '0);
    push(1'b1, 1'b1, ROW_W'(3), COL_W'(1), DATA_W'('hDEAD));
    drain("t4_drain");
    check("t4_err_timeout", err_timeout, 1'b1);
    never_ack = 0; ack_delay = 1;
    push(1'b0, 1'b0, ROW_W'(3), COL_W'(1), '0);
    drain("t4_readback_drain");
    check("t4_err_sticky", err_timeout, 1'b1);

    // 5: reset mid-write clears everything at once
    stall = 1; no_commit = 1;
    push(1'b1, 1'b1, ROW_W'(9), COL_W'(2), DATA_W'('hABCD));
    n = 0;
    while (!mem_write_en && n < 20) begin @(negedge clock); n++; end
    check("t5_write_active", mem_write_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_mem_zero", {mem_read_en, mem_write_en, mem_pad_en, mem_row_addr, mem_col_addr, mem_wdata}, '0);
    check("t5_err_cleared", err_timeout, 1'b0);
    exp_req.delete(); exp_rsp.delete();
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    stall = 0; no_commit = 0;
    @(negedge clock);
    check("t5_idle", idle, 1'b1);
    check("t5_cmd_ready", cmd_ready, 1'b1);

    // 6: back-to-back writes keep exactly one low cycle between requests
    ack_delay = 1; gap_armed = 1; gap_rises = 0;
    push(1'b1, 1'b0, ROW_W'(1), COL_W'(3), $urandom);
    push(1'b1, 1'b1, ROW_W'(2), COL_W'(2), $urandom);
    push(1'b1, 1'b0, ROW_W'(3), COL_W'(1), $urandom);
    drain("t6_drain");
    gap_armed = 0;
    check("t6_issue_count", gap_rises, 3);

    // Random traffic with random ack delay and response back-pressure
    rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(0, 4);
      push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ROW_W'($urandom_range(0, 3)), COL_W'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clock);
    end
    drain("rand_drain");
    rsp_mode = 0;
    check("rand_no_timeout_added", err_timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
